testout_uart_tx: RTL and testbench

TESTOUT_UART_TX -- requirements
Module: testout_uart_tx

---
 rtl/mips_pkg.sv | 21 ++
 rtl/uart_byte_tx.sv | 125 ++++++++++++
 rtl/testout_uart_tx.sv | 105 ++++++++++
 tb/tb_testout_uart_tx.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the testOut UART path: TX state encoding, word size
// and UART line levels. TESTOUT_PARITY_EN adds the PARITY state.
package mips_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;

  localparam logic UART_IDLE  = 1'b1;
  localparam logic UART_START = 1'b0;
  localparam logic UART_STOP  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef TESTOUT_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_byte_tx.sv
// Byte serialiser: START, 8 data bits LSB first, optional even parity
// (TESTOUT_PARITY_EN), STOP; each bit held CLKS_PER_BIT cycles.
module uart_byte_tx
  import mips_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_txd
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_t   r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_txd;
`ifdef TESTOUT_PARITY_EN
  logic        r_parity;
`endif

  logic w_last;
  assign w_last = (r_timer == TW'(CLKS_PER_BIT - 1));

  // Ready in IDLE and on the final STOP cycle, so a queued byte follows with no idle gap.
  assign o_ready = (r_state == ST_IDLE) || ((r_state == ST_STOP) && w_last);
  assign o_txd   = r_txd;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_txd    <= UART_IDLE;
`ifdef TESTOUT_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          if (i_start) begin
            r_state  <= ST_START;
            r_txd    <= UART_START;
            r_shift  <= i_data;
`ifdef TESTOUT_PARITY_EN
            r_parity <= ^i_data;
`endif
          end
        end
        ST_START: begin
          if (w_last) begin
            r_state <= ST_DATA;
            r_timer <= '0;
            r_bit   <= '0;
            r_txd   <= r_shift[0];
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_last) begin
            r_timer <= '0;
            if (r_bit == 3'd7) begin
`ifdef TESTOUT_PARITY_EN
              r_state <= ST_PARITY;
              r_txd   <= r_parity;
`else
              r_state <= ST_STOP;
              r_txd   <= UART_STOP;
`endif
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_txd   <= r_shift[1];
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
`ifdef TESTOUT_PARITY_EN
        ST_PARITY: begin
          if (w_last) begin
            r_state <= ST_STOP;
            r_timer <= '0;
            r_txd   <= UART_STOP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (w_last) begin
            r_timer <= '0;
            if (i_start) begin
              r_state  <= ST_START;
              r_txd    <= UART_START;
              r_shift  <= i_data;
`ifdef TESTOUT_PARITY_EN
              r_parity <= ^i_data;
`endif
            end else begin
              r_state <= ST_IDLE;
              r_txd   <= UART_IDLE;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_timer <= '0;
          r_txd   <= UART_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/testout_uart_tx.sv
// Streams every change of the Mips_Top testOut word over UART, LSB byte first,
// through a small FIFO. Define TESTOUT_PARITY_EN for an even-parity bit per byte.
module testout_uart_tx
  import mips_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] testOut,
  output logic        TxD,
  output logic        Busy,
  output logic        Overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [31:0] r_prev_q;
  logic [31:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic        r_overflow;
  logic [31:0] r_shift;
  logic [1:0]  r_idx;
  logic        r_active;

  logic        w_empty;
  logic        w_full;
  logic [31:0] w_head;
  logic        w_change;
  logic        w_more;
  logic        w_ready;
  logic        w_load;
  logic        w_pop;
  logic        w_push;
  logic [7:0]  w_byte;
  logic        w_txd;

  assign w_empty  = (r_wr == r_rd);
  assign w_full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_head   = r_mem[r_rd[AW-1:0]];
  assign w_change = (testOut != r_prev_q);

  // Remaining bytes of the current word take priority over fetching a new word.
  assign w_more   = r_active && (r_idx != 2'(BYTES_PER_WORD - 1));
  assign w_load   = w_ready && (w_more || !w_empty);
  assign w_pop    = w_ready && !w_more && !w_empty;
  assign w_byte   = w_more ? r_shift[7:0] : w_head[7:0];
  assign w_push   = w_change && (!w_full || w_pop);

  assign TxD      = w_txd;
  assign Busy     = r_active || !w_empty;
  assign Overflow = r_overflow;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_prev_q   <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_prev_q <= testOut;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_change && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= testOut;
  end

  // Byte 0 goes straight from the FIFO head; the shift register keeps bytes 1..3.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shift  <= '0;
      r_idx    <= '0;
      r_active <= 1'b0;
    end else if (w_load) begin
      if (w_more) begin
        r_shift <= {8'h00, r_shift[31:8]};
        r_idx   <= r_idx + 1'b1;
      end else begin
        r_shift  <= {8'h00, w_head[31:8]};
        r_idx    <= '0;
        r_active <= 1'b1;
      end
    end else if (w_ready) begin
      r_active <= 1'b0;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .i_clk  (CLK),
    .i_rst_n(RST),
    .i_start(w_load),
    .i_data (w_byte),
    .o_ready(w_ready),
    .o_txd  (w_txd)
  );

endmodule

// File: tb/tb_testout_uart_tx.sv
// Directed bench for testout_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4); a line
// monitor decodes TxD into bytes. Honours TESTOUT_PARITY_EN.
module tb_testout_uart_tx;

  localparam int CPB = 4;
`ifdef TESTOUT_PARITY_EN
  localparam int BITS = 11;
`else
  localparam int BITS = 10;
`endif
  localparam int FRAME = 4 * BITS * CPB;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] testOut;
  logic        TxD;
  logic        Busy;
  logic        Overflow;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mon_bytes [$];
  int          mon_ferr = 0;
  logic [7:0]  mon_b;
`ifdef TESTOUT_PARITY_EN
  logic        mon_par [$];
  logic        mon_p;
`endif
  logic [31:0] vec [6];

  testout_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .testOut (testOut),
    .TxD     (TxD),
    .Busy    (Busy),
    .Overflow(Overflow)
  );

  always #5 CLK = ~CLK;

  // Line monitor: samples each bit 2.5 cycles into its period.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST === 1'b1 && TxD === 1'b0) begin
        repeat (2) @(negedge CLK);
        if (TxD === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge CLK);
            mon_b[i] = TxD;
          end
`ifdef TESTOUT_PARITY_EN
          repeat (CPB) @(negedge CLK);
          mon_p = TxD;
`endif
          repeat (CPB) @(negedge CLK);
          if (TxD !== 1'b1) mon_ferr++;
          else begin
            mon_bytes.push_back(mon_b);
`ifdef TESTOUT_PARITY_EN
            mon_par.push_back(mon_p);
`endif
          end
        end
      end
    end
  end

  task automatic send_burst(input int n);
    @(posedge CLK); #1 testOut = vec[0];
    for (int i = 1; i < n; i++) begin
      @(posedge CLK); #1 testOut = vec[i];
    end
  endtask

  task automatic wait_idle(input int max, output int cyc);
    cyc = 0;
    while (Busy === 1'b1 && cyc < max) begin
      @(posedge CLK); #1;
      cyc++;
    end
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    int bad;
    RST = 1'b1; testOut = '0;
    #1 RST = 1'b0;
    #1;
    checks++; if (TxD !== 1'b1) begin failures++; $display("FAIL reset_txd: got %b expected 1", TxD); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", Overflow); end
    #2 RST = 1'b1;
    bad = 0;
    repeat (30) begin
      @(posedge CLK); #1;
      if (TxD !== 1'b1 || Busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL reset_quiet: got %0d active cycles expected 0", bad); end
    checks++; if (mon_bytes.size() != 0) begin failures++; $display("FAIL reset_noframe: got %0d bytes expected 0", mon_bytes.size()); end
  endtask

  task automatic test_single_word();
    int n, m;
    logic [7:0] exp_b [4];
    logic [7:0] got;
    exp_b[0] = 8'h44; exp_b[1] = 8'h33; exp_b[2] = 8'h22; exp_b[3] = 8'h11;
    mon_bytes.delete();
    @(posedge CLK); #1 testOut = 32'h11223344;
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (TxD !== 1'b0 && n < 10);
    checks++; if (n != 2) begin failures++; $display("FAIL single_latency: got %0d cycles expected 2", n); end
    m = 0;
    while (Busy === 1'b1 && m < 400) begin @(posedge CLK); #1; m++; end
    checks++; if (m != FRAME) begin failures++; $display("FAIL single_frame_len: got %0d cycles expected %0d", m, FRAME); end
    checks++; if (TxD !== 1'b1) begin failures++; $display("FAIL single_idle_txd: got %b expected 1", TxD); end
    repeat (4) @(posedge CLK);
    #1;
    checks++; if (mon_bytes.size() != 4) begin failures++; $display("FAIL single_count: got %0d bytes expected 4", mon_bytes.size()); end
    for (int k = 0; k < 4; k++) begin
      got = (k < mon_bytes.size()) ? mon_bytes[k] : 8'hxx;
      checks++; if (got !== exp_b[k]) begin failures++; $display("FAIL single_byte%0d: got %h expected %h", k, got, exp_b[k]); end
    end
  endtask

  task automatic test_burst();
    int c, idx;
    logic [31:0] w;
    logic [7:0] got;
    vec[0] = 32'hA0A1A2A3; vec[1] = 32'hB0B1B2B3; vec[2] = 32'hC0C1C2C3;
    vec[3] = 32'hD0D1D2D3; vec[4] = 32'hE0E1E2E3;
    mon_bytes.delete();
    send_burst(5);
    wait_idle(2000, c);
    checks++; if (c >= 2000) begin failures++; $display("FAIL burst_timeout: waited %0d cycles", c); end
    checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL burst_overflow: got %b expected 0", Overflow); end
    checks++; if (mon_bytes.size() != 20) begin failures++; $display("FAIL burst_count: got %0d bytes expected 20", mon_bytes.size()); end
    for (int i = 0; i < 5; i++) begin
      w = vec[i];
      for (int k = 0; k < 4; k++) begin
        idx = i * 4 + k;
        got = (idx < mon_bytes.size()) ? mon_bytes[idx] : 8'hxx;
        checks++; if (got !== w[8*k +: 8]) begin failures++; $display("FAIL burst_byte%0d: got %h expected %h", idx, got, w[8*k +: 8]); end
      end
    end
  endtask

  task automatic test_full_simultaneous_pop();
    int c, idx;
    logic [31:0] w;
    logic [7:0] got;
    vec[0] = 32'h01020304; vec[1] = 32'h05060708; vec[2] = 32'h090A0B0C;
    vec[3] = 32'h0D0E0F10; vec[4] = 32'h11121314; vec[5] = 32'h15161718;
    mon_bytes.delete();
    send_burst(5);
    // First word popped 2 edges after vec[0]; its frame ends FRAME edges later.
    repeat (FRAME - 3) @(posedge CLK);
    #1 testOut = vec[5];
    wait_idle(2000, c);
    checks++; if (c >= 2000) begin failures++; $display("FAIL fullpop_timeout: waited %0d cycles", c); end
    checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL fullpop_overflow: got %b expected 0", Overflow); end
    checks++; if (mon_bytes.size() != 24) begin failures++; $display("FAIL fullpop_count: got %0d bytes expected 24", mon_bytes.size()); end
    for (int i = 0; i < 6; i++) begin
      w = vec[i];
      for (int k = 0; k < 4; k++) begin
        idx = i * 4 + k;
        got = (idx < mon_bytes.size()) ? mon_bytes[idx] : 8'hxx;
        checks++; if (got !== w[8*k +: 8]) begin failures++; $display("FAIL fullpop_byte%0d: got %h expected %h", idx, got, w[8*k +: 8]); end
      end
    end
  endtask

  task automatic test_overflow();
    int c, idx;
    logic [31:0] w;
    logic [7:0] got;
    vec[0] = 32'h2A2B2C2D; vec[1] = 32'h3A3B3C3D; vec[2] = 32'h4A4B4C4D;
    vec[3] = 32'h5A5B5C5D; vec[4] = 32'h6A6B6C6D; vec[5] = 32'h7A7B7C7D;
    mon_bytes.delete();
    send_burst(5);
    repeat (10) @(posedge CLK);
    #1 testOut = vec[5];
    @(posedge CLK); #1;
    checks++; if (Overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b expected 1", Overflow); end
    wait_idle(2000, c);
    checks++; if (Overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected 1", Overflow); end
    checks++; if (mon_bytes.size() != 20) begin failures++; $display("FAIL ovf_count: got %0d bytes expected 20", mon_bytes.size()); end
    for (int i = 0; i < 5; i++) begin
      w = vec[i];
      for (int k = 0; k < 4; k++) begin
        idx = i * 4 + k;
        got = (idx < mon_bytes.size()) ? mon_bytes[idx] : 8'hxx;
        checks++; if (got !== w[8*k +: 8]) begin failures++; $display("FAIL ovf_byte%0d: got %h expected %h", idx, got, w[8*k +: 8]); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int n, bad;
    @(posedge CLK); #3 RST = 1'b0; testOut = '0;
    #1;
    checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL ovf_cleared: got %b expected 0", Overflow); end
    @(negedge CLK); #2 RST = 1'b1;
    mon_bytes.delete();
    @(posedge CLK); #1 testOut = 32'hA1B2C3D4;
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (TxD !== 1'b0 && n < 10);
    // Byte 2 (0xB2) data bit 0 is low from 84 to 87 cycles after the frame start.
    repeat (85) @(posedge CLK);
    #3;
    checks++; if (TxD !== 1'b0) begin failures++; $display("FAIL midrst_pre_txd: got %b expected 0", TxD); end
    RST = 1'b0;
    #1;
    checks++; if (TxD !== 1'b1) begin failures++; $display("FAIL midrst_txd: got %b expected 1", TxD); end
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", Busy); end
    testOut = '0;
    #3 RST = 1'b1;
    bad = 0;
    repeat (200) begin
      @(posedge CLK); #1;
      if (TxD !== 1'b1 || Busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", bad); end
    mon_bytes.delete();
  endtask

  task automatic test_capture_after_reset();
    int n, c;
    logic [7:0] exp_b [4];
    logic [7:0] got;
    exp_b[0] = 8'h5A; exp_b[1] = 8'h00; exp_b[2] = 8'h00; exp_b[3] = 8'h00;
    @(posedge CLK); #1 RST = 1'b0; testOut = 32'h0000005A;
    #3 RST = 1'b1;
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (TxD !== 1'b0 && n < 10);
    checks++; if (n != 2) begin failures++; $display("FAIL capture_latency: got %0d cycles expected 2", n); end
    wait_idle(400, c);
    checks++; if (mon_bytes.size() != 4) begin failures++; $display("FAIL capture_count: got %0d bytes expected 4", mon_bytes.size()); end
    for (int k = 0; k < 4; k++) begin
      got = (k < mon_bytes.size()) ? mon_bytes[k] : 8'hxx;
      checks++; if (got !== exp_b[k]) begin failures++; $display("FAIL capture_byte%0d: got %h expected %h", k, got, exp_b[k]); end
    end
  endtask

`ifdef TESTOUT_PARITY_EN
  task automatic test_parity();
    int n, m;
    logic [7:0] exp_b [4];
    logic       exp_p [4];
    logic [7:0] got;
    logic       gp;
    exp_b[0] = 8'h07; exp_b[1] = 8'h00; exp_b[2] = 8'h00; exp_b[3] = 8'h00;
    exp_p[0] = 1'b1;  exp_p[1] = 1'b0;  exp_p[2] = 1'b0;  exp_p[3] = 1'b0;
    mon_bytes.delete();
    mon_par.delete();
    @(posedge CLK); #1 testOut = 32'h00000007;
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (TxD !== 1'b0 && n < 10);
    checks++; if (n != 2) begin failures++; $display("FAIL parity_latency: got %0d cycles expected 2", n); end
    m = 0;
    while (Busy === 1'b1 && m < 400) begin @(posedge CLK); #1; m++; end
    checks++; if (m != 176) begin failures++; $display("FAIL parity_frame_len: got %0d cycles expected 176", m); end
    repeat (4) @(posedge CLK);
    #1;
    checks++; if (mon_bytes.size() != 4) begin failures++; $display("FAIL parity_count: got %0d bytes expected 4", mon_bytes.size()); end
    for (int k = 0; k < 4; k++) begin
      got = (k < mon_bytes.size()) ? mon_bytes[k] : 8'hxx;
      gp  = (k < mon_par.size()) ? mon_par[k] : 1'bx;
      checks++; if (got !== exp_b[k]) begin failures++; $display("FAIL parity_byte%0d: got %h expected %h", k, got, exp_b[k]); end
      checks++; if (gp !== exp_p[k]) begin failures++; $display("FAIL parity_bit%0d: got %b expected %b", k, gp, exp_p[k]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_burst();
    test_full_simultaneous_pop();
    test_overflow();
    test_reset_mid_frame();
    test_capture_after_reset();
`ifdef TESTOUT_PARITY_EN
    test_parity();
`endif
    checks++; if (mon_ferr != 0) begin failures++; $display("FAIL framing: got %0d bad stop bits expected 0", mon_ferr); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
